// File: rtl/ram_arbiter.sv
// Three-way SRAM arbiter (video > starved DMA > CPU > DMA); every access is ADDR then DATA.
// Define RAM_ARB_DMA_EN to build the DMA port and its starvation counter.
module ram_arbiter #(
   parameter int DMA_STARVE_MAX = 4
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        video_req,
   input  logic [18:0] video_addr,
   output logic        video_ack,
   output logic [7:0]  video_rdata,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [18:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_wait,
   input  logic        dma_req,
   input  logic        dma_wr,
   input  logic [18:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic [18:0] ram_a,
   output logic [7:0]  ram_dout,
   output logic        ram_dout_oe,
   input  logic [7:0]  ram_din,
   output logic        ram_n_oe,
   output logic        ram_n_we
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_VID = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

   localparam logic [2:0] STARVE_MAX = 3'(DMA_STARVE_MAX);

   state_t      state_r, state_s;
   owner_t      owner_r, grant_s;
   logic        done_s, grant_en_s, any_pend_s, starved_s;
   logic        vid_pend_s, cpu_pend_s, dma_pend_s;
   logic        wr_r, wr_s;
   logic [18:0] addr_r, addr_s;
   logic [7:0]  wdata_r, wdata_s;
   logic        video_ack_r, cpu_ack_r, dma_ack_r;
   logic [7:0]  video_rdata_r, cpu_rdata_r, dma_rdata_r;
   logic        ram_n_oe_r, ram_n_we_r, ram_dout_oe_r;

   // A requester still holding req while its own access finishes or is being acked is not a new request.
   assign done_s     = (state_r == DATA);
   assign vid_pend_s = video_req && !video_ack_r && !(done_s && owner_r == OWN_VID);
   assign cpu_pend_s = cpu_req && !cpu_ack_r && !(done_s && owner_r == OWN_CPU);

`ifdef RAM_ARB_DMA_EN
   logic [2:0] starve_r;

   assign dma_pend_s = dma_req && !dma_ack_r && !(done_s && owner_r == OWN_DMA);
   assign starved_s  = (starve_r >= STARVE_MAX);

   // Starvation counter: counts CPU grants that overtook a waiting DMA request
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         starve_r <= 3'd0;
      end else if (!dma_req) begin
         starve_r <= 3'd0;
      end else if (grant_en_s && grant_s == OWN_DMA) begin
         starve_r <= 3'd0;
      end else if (grant_en_s && grant_s == OWN_CPU && starve_r < STARVE_MAX) begin
         starve_r <= starve_r + 3'd1;
      end
   end
`else
   logic dma_unused_s;

   assign dma_pend_s   = 1'b0;
   assign starved_s    = 1'b0;
   assign dma_unused_s = ^{dma_req, STARVE_MAX};
`endif

   assign any_pend_s = vid_pend_s || cpu_pend_s || dma_pend_s;

   // Priority select of the next owner
   always_comb begin
      grant_s = OWN_CPU;
      if (vid_pend_s) begin
         grant_s = OWN_VID;
      end else if (dma_pend_s && starved_s) begin
         grant_s = OWN_DMA;
      end else if (cpu_pend_s) begin
         grant_s = OWN_CPU;
      end else if (dma_pend_s) begin
         grant_s = OWN_DMA;
      end else begin
         grant_s = OWN_CPU;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (any_pend_s) state_s = ADDR; else state_s = IDLE;
         ADDR:    state_s = DATA;
         DATA:    if (any_pend_s) state_s = ADDR; else state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign grant_en_s = (state_s == ADDR) && (state_r != ADDR);

   // Address, direction and write data are latched only at grant
   always_comb begin
      addr_s  = addr_r;
      wr_s    = wr_r;
      wdata_s = wdata_r;
      if (grant_en_s) begin
         case (grant_s)
            OWN_VID: begin addr_s = video_addr; wr_s = 1'b0; end
            OWN_CPU: begin addr_s = cpu_addr; wr_s = cpu_wr; wdata_s = cpu_wdata; end
            OWN_DMA: begin addr_s = dma_addr; wr_s = dma_wr; wdata_s = dma_wdata; end
            default: begin addr_s = addr_r; wr_s = wr_r; wdata_s = wdata_r; end
         endcase
      end else begin
         addr_s  = addr_r;
         wr_s    = wr_r;
         wdata_s = wdata_r;
      end
   end

   // FSM, access registers and SRAM strobes (read: OE over ADDR+DATA; write: WE in DATA only)
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         owner_r       <= OWN_VID;
         addr_r        <= 19'd0;
         wr_r          <= 1'b0;
         wdata_r       <= 8'd0;
         ram_n_oe_r    <= 1'b1;
         ram_n_we_r    <= 1'b1;
         ram_dout_oe_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         if (grant_en_s) owner_r <= grant_s;
         addr_r        <= addr_s;
         wr_r          <= wr_s;
         wdata_r       <= wdata_s;
         ram_n_oe_r    <= !((state_s != IDLE) && !wr_s);
         ram_dout_oe_r <= (state_s != IDLE) && wr_s;
         ram_n_we_r    <= !((state_s == DATA) && wr_s);
      end
   end

   // Completion: ack pulse and read data land in the cycle after DATA
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         video_ack_r   <= 1'b0;
         cpu_ack_r     <= 1'b0;
         dma_ack_r     <= 1'b0;
         video_rdata_r <= 8'd0;
         cpu_rdata_r   <= 8'd0;
         dma_rdata_r   <= 8'd0;
      end else begin
         video_ack_r <= done_s && owner_r == OWN_VID;
         cpu_ack_r   <= done_s && owner_r == OWN_CPU;
         dma_ack_r   <= done_s && owner_r == OWN_DMA;
         if (done_s && owner_r == OWN_VID) video_rdata_r <= ram_din;
         if (done_s && owner_r == OWN_CPU && !wr_r) cpu_rdata_r <= ram_din;
         if (done_s && owner_r == OWN_DMA && !wr_r) dma_rdata_r <= ram_din;
      end
   end

   assign video_ack   = video_ack_r;
   assign video_rdata = video_rdata_r;
   assign cpu_ack     = cpu_ack_r;
   assign cpu_rdata   = cpu_rdata_r;
   assign cpu_wait    = rst_n && cpu_req && !cpu_ack_r;
   assign dma_ack     = dma_ack_r;
   assign dma_rdata   = dma_rdata_r;
   assign ram_a       = addr_r;
   assign ram_dout    = wdata_r;
   assign ram_dout_oe = ram_dout_oe_r;
   assign ram_n_oe    = ram_n_oe_r;
   assign ram_n_we    = ram_n_we_r;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter; expectations follow RAM_ARB_DMA_EN.
module tb_ram_arbiter;
`ifdef RAM_ARB_DMA_EN
   localparam bit DMA_ON = 1'b1;
`else
   localparam bit DMA_ON = 1'b0;
`endif

   logic        clk28 = 1'b0;
   logic        rst_n;
   logic        video_req, video_ack;
   logic [18:0] video_addr;
   logic [7:0]  video_rdata;
   logic        cpu_req, cpu_wr, cpu_ack, cpu_wait;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        dma_req, dma_wr, dma_ack;
   logic [18:0] dma_addr;
   logic [7:0]  dma_wdata, dma_rdata;
   logic [18:0] ram_a;
   logic [7:0]  ram_dout, ram_din;
   logic        ram_dout_oe, ram_n_oe, ram_n_we;

   int total = 0;
   int bad   = 0;

   ram_arbiter #(.DMA_STARVE_MAX(4)) dut (
      .clk28(clk28), .rst_n(rst_n),
      .video_req(video_req), .video_addr(video_addr), .video_ack(video_ack), .video_rdata(video_rdata),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe), .ram_din(ram_din),
      .ram_n_oe(ram_n_oe), .ram_n_we(ram_n_we)
   );

   always #5 clk28 = ~clk28;

   typedef struct {
      logic        vreq, creq, cwr, dreq;
      logic [18:0] caddr;
      logic [7:0]  cwdata, din;
      logic        noe, nwe, doe, vack, cack, dack;
      logic [18:0] a;
      logic [7:0]  crd, vrd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic vreq, input logic creq, input logic cwr, input logic dreq,
                               input logic [18:0] caddr, input logic [7:0] cwdata, input logic [7:0] din,
                               input logic noe, input logic nwe, input logic doe,
                               input logic vack, input logic cack, input logic dack,
                               input logic [18:0] a, input logic [7:0] crd, input logic [7:0] vrd);
      vec_t v;
      v.vreq = vreq; v.creq = creq; v.cwr = cwr; v.dreq = dreq;
      v.caddr = caddr; v.cwdata = cwdata; v.din = din;
      v.noe = noe; v.nwe = nwe; v.doe = doe;
      v.vack = vack; v.cack = cack; v.dack = dack;
      v.a = a; v.crd = crd; v.vrd = vrd;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk28);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      int          n;
      logic        ack_seen;
      logic        multi;
      string       seq;
      string       exp_seq;

      rst_n = 1'b0;
      video_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
      cpu_wr = 1'b0; dma_wr = 1'b0;
      video_addr = 19'h12345; cpu_addr = 19'h00000; dma_addr = 19'h6789A;
      cpu_wdata = 8'h00; dma_wdata = 8'h00; ram_din = 8'h00;

      // CPU read, 0x1ABCD -> 0x5A
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h5A, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h5A, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h00));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h5A, 1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 19'h1ABCD, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0, 19'h1ABCD, 8'h00, 8'h5A, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h1ABCD, 8'h5A, 8'h00));
      // CPU write 0x3C to 0x04000
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 19'h04000, 8'h3C, 8'h00, 1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 19'h04000, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 19'h04000, 8'h3C, 8'h00, 1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0, 19'h04000, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 19'h04000, 8'h3C, 8'h00, 1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 19'h04000, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0, 19'h04000, 8'h3C, 8'h00, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h04000, 8'h5A, 8'h00));
      // Video, CPU and DMA requested together; each drops its request after its ack
      vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1, 19'h00777, 8'h00, 8'h00, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h12345, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1, 19'h00777, 8'h00, 8'h00, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h12345, 8'h5A, 8'h00));
      vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1, 19'h00777, 8'h00, 8'h11, 1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0, 19'h00777, 8'h5A, 8'h11));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1, 19'h00777, 8'h00, 8'h00, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 19'h00777, 8'h5A, 8'h11));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1, 19'h00777, 8'h00, 8'h22, !DMA_ON,1'b1,1'b0, 1'b0,1'b1,1'b0,
                        DMA_ON ? 19'h6789A : 19'h00777, 8'h22, 8'h11));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1, 19'h00777, 8'h00, 8'h00, !DMA_ON,1'b1,1'b0, 1'b0,1'b0,1'b0,
                        DMA_ON ? 19'h6789A : 19'h00777, 8'h22, 8'h11));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1, 19'h00777, 8'h00, 8'h33, 1'b1,1'b1,1'b0, 1'b0,1'b0,DMA_ON,
                        DMA_ON ? 19'h6789A : 19'h00777, 8'h22, 8'h11));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0, 19'h00777, 8'h00, 8'h00, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,
                        DMA_ON ? 19'h6789A : 19'h00777, 8'h22, 8'h11));

      // Reset state, with requests asserted during reset
      tick();
      tick();
      check("reset_state",
            64'({ram_n_oe, ram_n_we, ram_dout_oe, video_ack, cpu_ack, dma_ack, cpu_wait, ram_a,
                 cpu_rdata, video_rdata, dma_rdata}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0, 8'h00, 8'h00, 8'h00}));
      video_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         video_req = vecs[i].vreq; cpu_req = vecs[i].creq; cpu_wr = vecs[i].cwr; dma_req = vecs[i].dreq;
         cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata; ram_din = vecs[i].din;
         tick();
         check($sformatf("vec%0d", i),
               64'({ram_n_oe, ram_n_we, ram_dout_oe, video_ack, cpu_ack, dma_ack, cpu_wait, ram_a,
                    cpu_rdata, video_rdata}),
               64'({vecs[i].noe, vecs[i].nwe, vecs[i].doe, vecs[i].vack, vecs[i].cack, vecs[i].dack,
                    vecs[i].creq & ~vecs[i].cack, vecs[i].a, vecs[i].crd, vecs[i].vrd}));
         if (vecs[i].doe) check($sformatf("vec%0d_dout", i), 64'(ram_dout), 64'(vecs[i].cwdata));
      end
      check("dma_rdata", 64'(dma_rdata), DMA_ON ? 64'h33 : 64'h00);

      // Reset pulse during DATA of a write aborts it without an ack
      cpu_addr = 19'h0ABCD; cpu_wdata = 8'hE7; cpu_wr = 1'b1; cpu_req = 1'b1;
      tick();
      tick();
      check("abort_pre_we", 64'({ram_n_we, ram_dout_oe}), 64'({1'b0, 1'b1}));
      rst_n = 1'b0;
      #1;
      check("abort_in_reset", 64'({ram_n_we, ram_n_oe, ram_dout_oe, cpu_wait, ram_a}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 19'h0}));
      cpu_req = 1'b0;
      #2;
      rst_n = 1'b1;
      ack_seen = 1'b0;
      repeat (4) begin
         tick();
         if (cpu_ack) ack_seen = 1'b1;
      end
      check("abort_no_ack", 64'(ack_seen), 64'd0);

      cpu_wr = 1'b0; cpu_addr = 19'h00100; ram_din = 8'hC3; cpu_req = 1'b1;
      tick();
      check("post_abort_grant", 64'({ram_n_oe, ram_a}), 64'({1'b0, 19'h00100}));
      n = 1;
      while (!cpu_ack && n < 8) begin
         tick();
         n++;
      end
      check("post_abort_latency", 64'(n), 64'd3);
      check("post_abort_rdata", 64'(cpu_rdata), 64'hC3);
      cpu_req = 1'b0;
      tick();

      // All three requesters continuously busy: order reveals the starvation promotion
      video_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1; cpu_wr = 1'b0;
      exp_seq = DMA_ON ? "VCVCVCVCVD" : "VCVCVCVCVC";
      seq = "";
      multi = 1'b0;
      n = 0;
      while (seq.len() < 10 && n < 80) begin
         tick();
         n++;
         if ($countones({video_ack, cpu_ack, dma_ack}) > 1) multi = 1'b1;
         if (video_ack) seq = {seq, "V"};
         else if (cpu_ack) seq = {seq, "C"};
         else if (dma_ack) seq = {seq, "D"};
      end
      total++;
      if (seq != exp_seq) begin
         bad++;
         $display("FAIL ack_order: actual=%s expected=%s", seq, exp_seq);
      end
      check("ack_onehot", 64'(multi), 64'd0);

      video_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      repeat (6) tick();
      check("drain_idle", 64'({ram_n_oe, ram_n_we, ram_dout_oe, video_ack, cpu_ack, dma_ack}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DMA_STARVE_MAX, default 4: consecutive CPU grants after which a pending DMA request wins over a CPU request.
REQ-002 clk28  in  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 video_req  in  1  video fetch request, level; held until video_ack.
REQ-005 video_addr  in  19  video fetch address.
REQ-006 video_ack  out  1  one-cycle pulse; video_rdata valid in the same cycle.
REQ-007 video_rdata  out  8  video read data.
REQ-008 cpu_req  in  1  CPU memory request, level; held until cpu_ack.
REQ-009 cpu_wr  in  1  1 = write, 0 = read; sampled at grant.
REQ-010 cpu_addr  in  19  CPU physical address.
REQ-011 cpu_wdata  in  8  CPU write data.
REQ-012 cpu_ack  out  1  one-cycle completion pulse.
REQ-013 cpu_rdata  out  8  CPU read data, held until the next CPU read completes.
REQ-014 cpu_wait  out  1  high while cpu_req is pending and not yet acked; feeds the CPU clock-stretch logic.
REQ-015 dma_req, dma_wr, dma_addr[18:0], dma_wdata[7:0]  in  as CPU  DMA requester, same rules as CPU.
REQ-016 dma_ack  out  1, dma_rdata  out  8  as CPU.
REQ-017 ram_a  out  19, ram_dout  out  8, ram_dout_oe  out  1, ram_din  in  8, ram_n_oe  out  1, ram_n_we  out  1  SRAM pins.

Function
REQ-018 FSM states IDLE, ADDR, DATA; each access takes exactly 2 clk28 cycles (ADDR then DATA).
REQ-019 IDLE->ADDR when any request is pending; ADDR->DATA always; DATA->ADDR when another request is pending at that edge, otherwise DATA->IDLE (back-to-back accesses with no idle cycle).
REQ-020 Grant is decided on entry to ADDR; priority video > DMA-if-starved > CPU > DMA.
REQ-021 Starve counter (3 bits, saturating at DMA_STARVE_MAX): increments on each CPU grant while dma_req is high; clears on a DMA grant or when dma_req is low.
REQ-022 ram_a, write data and direction are registered at grant and held stable through ADDR and DATA.
REQ-023 Read: ram_n_oe low during ADDR and DATA; ram_din is captured at the end of DATA; the ack pulse and rdata update occur in the cycle after DATA, so latency is 3 cycles from grant to ack.
REQ-024 Write: ram_dout_oe high during ADDR and DATA; ram_n_we low during DATA only; the ack pulse occurs in the cycle after DATA.
REQ-025 ram_n_oe and ram_n_we are never low in the same cycle; ram_dout_oe is never high while ram_n_oe is low.
REQ-026 Simultaneous video, CPU and DMA requests are served in the order video, CPU, DMA, with each pair of accesses back-to-back.
REQ-027 A request deasserted before its grant is dropped without an ack; once granted, the access completes regardless of the request level.
REQ-028 Each granted access produces exactly one ack pulse, and only to its own requester.
REQ-029 In IDLE: ram_n_oe=1, ram_n_we=1, ram_dout_oe=0; ram_a holds its last value.

Reset
REQ-030 While rst_n is low: FSM=IDLE, all acks=0, cpu_wait=0, rdata=0, ram_n_oe=1, ram_n_we=1, ram_dout_oe=0, ram_a=0, starve counter=0.
REQ-031 Reset asserted mid-access aborts the access immediately; no ack is generated after release.
REQ-032 The first grant can occur on the first clock edge after rst_n rises.

Configuration
REQ-033 Macro RAM_ARB_DMA_EN: when defined, the DMA port and the starve counter are implemented as specified.
REQ-034 When RAM_ARB_DMA_EN is not defined: dma_req is ignored, dma_ack=0 and dma_rdata=0 at all times, the starve counter is not synthesized, and priority is video > CPU.

Verification
REQ-035 CPU read only, addr 0x1ABCD, ram_din=0x5A -> ram_n_oe low 2 cycles, cpu_ack 3 cycles after grant, cpu_rdata=0x5A.
REQ-036 CPU write 0x3C to 0x04000 -> ram_n_we low exactly 1 cycle (DATA), ram_dout=0x3C, ram_dout_oe high 2 cycles, cpu_ack 1 cycle later.
REQ-037 video, CPU and DMA requests all asserted in the same cycle -> grants in the order video, CPU, DMA at cycles 0, 2, 4; three acks, one each.
REQ-038 CPU requests continuously with DMA pending, DMA_STARVE_MAX=4 -> DMA is granted after the 4th CPU grant.
REQ-039 rst_n pulsed low during DATA of a write -> ram_n_we=1 immediately, no cpu_ack; a new request after release is served normally.
REQ-040 Build without RAM_ARB_DMA_EN, dma_req held high -> dma_ack never asserts and CPU and video timing are unchanged.
